reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Reset controller downstream of the reset RC-filter block. It arbitrates between the filtered system reset, an external fault level, software reboot and an optional watchdog. It releases the PLL, hub and cog reset domains in a fixed, timed order, then pulses boot_start. It also keeps a sticky reset-cause register that hub software can read.

Parameters:
HOLD_CYCLES, 32'd16, minimum cycles all domains stay in reset after the last active source.
PLL_WAIT, 32'd1600, minimum cycles between res_pll release and res_hub release (10 us at 160 MHz).
STAGE_GAP, 32'd4, cycles between res_hub release and res_cog release.
WDT_CYCLES, 32'd160_000_000, watchdog timeout in RUN (1 s); used only with WATCHDOG_EN.

Ports:
clock_160  in  1  system clock, all logic on rising edge
res        in  1  synchronous active-high reset (filtered system reset)
ext_fault  in  1  level; brown-out/external fault, forces reset while high
sw_reboot  in  1  single-cycle reboot request from hub
pll_lock   in  1  PLL lock indicator, already synchronous to clock_160
wdt_kick   in  1  watchdog reload pulse
cause_clr  in  1  clears cause register
res_pll    out 1  PLL domain reset, active high
res_hub    out 1  hub domain reset, active high
res_cog    out 1  cog domain reset, active high
boot_start out 1  one-cycle pulse when cogs leave reset
busy       out 1  high in every state except RUN
cause      out 3  sticky cause: [0] power-on/res, [1] software, [2] watchdog

Behaviour:
- All outputs are registered. Reset values (res high): res_pll=res_hub=res_cog=1, boot_start=0, busy=1, cause=3'b001, state=HOLD, cnt=HOLD_CYCLES-1.
- FSM states and outputs:
  - HOLD: all three resets high. cnt decrements each cycle. cnt reloads to HOLD_CYCLES-1 in any cycle where ext_fault=1. At cnt==0 -> PLL_WAIT with cnt=PLL_WAIT-1. res_pll falls exactly HOLD_CYCLES cycles after the last cycle res or ext_fault was sampled high.
  - PLL_WAIT: res_pll=0, others high. cnt decrements and saturates at 0. Exits when cnt==0 and pll_lock==1 -> HUB with cnt=STAGE_GAP-1. res_hub falls on the transition edge. If pll_lock is low, it stalls indefinitely.
  - HUB: res_pll=0, res_hub=0, res_cog=1. At cnt==0 -> RUN. res_cog falls and boot_start=1 for exactly that one cycle.
  - RUN: all resets 0, busy=0.
- Source arbitration:
  - ext_fault=1 in any state: next cycle state=HOLD, all resets=1, cnt reloaded. cause is unchanged (ext_fault is not a recorded cause).
  - sw_reboot is honoured only in RUN. It goes to HOLD and sets cause[1]. It is ignored in other states.
  - res has priority over everything. ext_fault has priority over sw_reboot and watchdog.
  - sw_reboot and watchdog expiry in the same cycle: both cause bits set.
- cause register:
  - Bits are sticky OR; nothing auto-clears them except res.
  - cause_clr zeroes all bits. A bit set in the same cycle as cause_clr survives (set wins).
  - res loads 3'b001 regardless of cause_clr.
- Widths: cnt is 32-bit unsigned. Parameter value 0 is treated as 1, i.e. the minimum one-cycle stage.

Optional Feature:
Macro WATCHDOG_EN.
- Defined:
  - 32-bit wdt counter loads WDT_CYCLES-1 on entry to RUN and on every wdt_kick while in RUN.
  - It decrements each RUN cycle. Reaching 0 while no kick is present -> HOLD next cycle and sets cause[2]. Timeout is exactly WDT_CYCLES cycles after RUN entry or the last kick.
  - Counter is frozen outside RUN.
- Undefined: no wdt logic, wdt_kick ignored, cause[2] constant 0, WDT_CYCLES unused.

Test Plan:
1. HOLD=16, PLL_WAIT=20, GAP=4, pll_lock=1. res high 3 cycles then low. Expect:
   - res_pll falls 16 cycles after res low; res_hub 20 cycles later; res_cog 4 cycles after that.
   - boot_start one-cycle pulse coincident with res_cog fall; busy=0; cause=001.
2. Same as 1 but pll_lock=0. Expect res_hub stays 1 for 200 cycles. Raise pll_lock -> res_hub falls on the next edge, res_cog 4 cycles later.
3. In RUN, pulse sw_reboot. Expect all resets=1 and busy=1 next cycle, cause=011, full sequence repeats.
4. ext_fault high for 5 cycles while in PLL_WAIT. Expect res_pll=1 next cycle; res_pll falls 16 cycles after ext_fault falls; cause unchanged.
5. WATCHDOG_EN, WDT_CYCLES=100:
   - No kicks: reboot 100 cycles after RUN entry, cause[2]=1.
   - Kick every 50 cycles for 1000 cycles: no reboot.
6. cause_clr and sw_reboot asserted in the same RUN cycle. Expect cause=010. A later cause_clr alone gives cause=000.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Reset controller that sits downstream of the reset RC filter. It arbitrates
//   between the filtered system reset, an external fault level, a software
//   reboot request and an optional watchdog. It releases the PLL, hub and cog
//   reset domains in a fixed, timed order and then pulses boot_start. It also
//   keeps a sticky reset-cause register for hub software.
//
//   Optional feature: define WATCHDOG_EN to build the RUN-state watchdog.
//   Without it, wdt_kick is ignored and cause[2] stays 0.
//
// Ports
//   clock_160  : system clock, all logic on the rising edge
//   res        : synchronous active-high reset (filtered system reset)
//   ext_fault  : brown-out / external fault level, holds reset while high
//   sw_reboot  : single-cycle reboot request from the hub (honoured in RUN)
//   pll_lock   : PLL lock indicator, already synchronous to clock_160
//   wdt_kick   : watchdog reload pulse
//   cause_clr  : clears the cause register
//   res_pll    : PLL domain reset, active high
//   res_hub    : hub domain reset, active high
//   res_cog    : cog domain reset, active high
//   boot_start : one-cycle pulse when the cogs leave reset
//   busy       : high in every state except RUN
//   cause      : sticky cause, [0] power-on/res, [1] software, [2] watchdog

module reset_sequencer #(
  parameter logic [31:0] HOLD_CYCLES = 32'd16,
  parameter logic [31:0] PLL_WAIT    = 32'd1600,
  parameter logic [31:0] STAGE_GAP   = 32'd4,
  parameter logic [31:0] WDT_CYCLES  = 32'd160_000_000
) (
  input  logic       clock_160,
  input  logic       res,
  input  logic       ext_fault,
  input  logic       sw_reboot,
  input  logic       pll_lock,
  input  logic       wdt_kick,
  input  logic       cause_clr,
  output logic       res_pll,
  output logic       res_hub,
  output logic       res_cog,
  output logic       boot_start,
  output logic       busy,
  output logic [2:0] cause
);

  // Counters load N-1 so a stage lasts N cycles; a zero parameter degenerates
  // to the one-cycle minimum stage.
  localparam logic [31:0] HOLD_LOAD = (HOLD_CYCLES == 32'd0) ? 32'd0 : HOLD_CYCLES - 32'd1;
  localparam logic [31:0] PLL_LOAD  = (PLL_WAIT    == 32'd0) ? 32'd0 : PLL_WAIT    - 32'd1;
  localparam logic [31:0] GAP_LOAD  = (STAGE_GAP   == 32'd0) ? 32'd0 : STAGE_GAP   - 32'd1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_PLL_WAIT,
    ST_HUB,
    ST_RUN
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        wdt_expire;
  logic        sw_take;
  logic        wdt_take;

`ifdef WATCHDOG_EN
  localparam logic [31:0] WDT_LOAD = (WDT_CYCLES == 32'd0) ? 32'd0 : WDT_CYCLES - 32'd1;

  logic [31:0] wdt;
  logic        run_entry;

  // Same condition the main FSM uses to step from HUB into RUN.
  assign run_entry = (state == ST_HUB) && (cnt == 32'd0) && !ext_fault;

  // Watchdog counter: reloaded on RUN entry and on every kick in RUN, counts
  // down during RUN and is frozen everywhere else.
  always_ff @(posedge clock_160) begin
    if (res) begin
      wdt <= WDT_LOAD;
    end else if (run_entry) begin
      wdt <= WDT_LOAD;
    end else if (state == ST_RUN) begin
      if (wdt_kick) begin
        wdt <= WDT_LOAD;
      end else if (wdt != 32'd0) begin
        wdt <= wdt - 32'd1;
      end
    end
  end

  // A kick in the expiry cycle still rescues the system.
  assign wdt_expire = (state == ST_RUN) && (wdt == 32'd0) && !wdt_kick;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (|WDT_CYCLES);
  assign wdt_expire = 1'b0;
`endif

  // External fault outranks both recorded reboot sources, so neither sets a
  // cause bit in a cycle where ext_fault is high.
  assign sw_take  = (state == ST_RUN) && sw_reboot && !ext_fault;
  assign wdt_take = wdt_expire && !ext_fault;

  // Sequencing FSM with registered outputs and the sticky cause register.
  always_ff @(posedge clock_160) begin
    if (res) begin
      state      <= ST_HOLD;
      cnt        <= HOLD_LOAD;
      res_pll    <= 1'b1;
      res_hub    <= 1'b1;
      res_cog    <= 1'b1;
      boot_start <= 1'b0;
      busy       <= 1'b1;
      cause      <= 3'b001;
    end else begin
      boot_start <= 1'b0;
      cause      <= (cause_clr ? 3'b000 : cause) | {wdt_take, sw_take, 1'b0};

      if (ext_fault) begin
        state   <= ST_HOLD;
        cnt     <= HOLD_LOAD;
        res_pll <= 1'b1;
        res_hub <= 1'b1;
        res_cog <= 1'b1;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == 32'd0) begin
              state   <= ST_PLL_WAIT;
              cnt     <= PLL_LOAD;
              res_pll <= 1'b0;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          // Counter saturates at zero so a late lock releases the hub on
          // the very next edge.
          ST_PLL_WAIT: begin
            if ((cnt == 32'd0) && pll_lock) begin
              state   <= ST_HUB;
              cnt     <= GAP_LOAD;
              res_hub <= 1'b0;
            end else if (cnt != 32'd0) begin
              cnt <= cnt - 32'd1;
            end
          end

          ST_HUB: begin
            if (cnt == 32'd0) begin
              state      <= ST_RUN;
              res_cog    <= 1'b0;
              busy       <= 1'b0;
              boot_start <= 1'b1;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end

          ST_RUN: begin
            if (sw_take || wdt_take) begin
              state   <= ST_HOLD;
              cnt     <= HOLD_LOAD;
              res_pll <= 1'b1;
              res_hub <= 1'b1;
              res_cog <= 1'b1;
              busy    <= 1'b1;
            end
          end

          default: begin
            state   <= ST_HOLD;
            cnt     <= HOLD_LOAD;
            res_pll <= 1'b1;
            res_hub <= 1'b1;
            res_cog <= 1'b1;
            busy    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Scoreboard bench for reset_sequencer. Each stimulus cycle runs a timeline
//   reference model (elapsed cycles since the last reset source, since each
//   domain release, since RUN entry or the last kick) and queues the expected
//   outputs; an independent monitor pops and compares after every clock edge.
//   Define WATCHDOG_EN for both DUT and bench to cover the watchdog.

`timescale 1ns/1ps

module tb_reset_sequencer;

  localparam int HC = 16;
  localparam int PW = 20;
  localparam int SG = 4;
  localparam int WD = 100;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ext_fault = 1'b0;
  logic       sw_reboot = 1'b0;
  logic       pll_lock = 1'b1;
  logic       wdt_kick = 1'b0;
  logic       cause_clr = 1'b0;
  logic       res_pll, res_hub, res_cog, boot_start, busy;
  logic [2:0] cause;

  reset_sequencer #(
    .HOLD_CYCLES(32'(HC)),
    .PLL_WAIT   (32'(PW)),
    .STAGE_GAP  (32'(SG)),
    .WDT_CYCLES (32'(WD))
  ) dut (
    .clock_160 (clk),
    .res       (res),
    .ext_fault (ext_fault),
    .sw_reboot (sw_reboot),
    .pll_lock  (pll_lock),
    .wdt_kick  (wdt_kick),
    .cause_clr (cause_clr),
    .res_pll   (res_pll),
    .res_hub   (res_hub),
    .res_cog   (res_cog),
    .boot_start(boot_start),
    .busy      (busy),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  // Expected output vectors: {res_pll, res_hub, res_cog, boot_start, busy, cause}
  logic [7:0] expQ[$];
  int total = 0;
  int bad = 0;

  // Reference model state, expressed as elapsed cycle counts.
  int         quiet = 0;
  int         pllAge = 0;
  int         hubAge = 0;
  int         runAge = 0;
  bit         pllRel = 0;
  bit         hubRel = 0;
  bit         cogRel = 0;
  logic [2:0] mCause = 3'b001;

  task modelStep(input bit r, input bit f, input bit sw, input bit lk,
                 input bit kk, input bit cl, output logic [7:0] e);
    bit         boot;
    bit         fire;
    bit         src;
    logic [2:0] nc;
    boot = 0;
    fire = 0;
    src  = 0;
    if (r) begin
      src    = 1;
      mCause = 3'b001;
    end else begin
      nc = cl ? 3'b000 : mCause;
      if (f) begin
        src = 1;
      end else if (cogRel) begin
`ifdef WATCHDOG_EN
        fire = !kk && (runAge + 1 >= WD);
`endif
        if (sw) nc[1] = 1'b1;
        if (fire) nc[2] = 1'b1;
        if (sw || fire) src = 1;
        else runAge = kk ? 0 : runAge + 1;
      end else if (!pllRel) begin
        quiet++;
        if (quiet >= HC) begin
          pllRel = 1;
          pllAge = 0;
        end
      end else if (!hubRel) begin
        pllAge++;
        if (pllAge >= PW && lk) begin
          hubRel = 1;
          hubAge = 0;
        end
      end else begin
        hubAge++;
        if (hubAge >= SG) begin
          cogRel = 1;
          boot   = 1;
          runAge = 0;
        end
      end
      mCause = nc;
    end
    if (src) begin
      quiet  = 0;
      pllRel = 0;
      hubRel = 0;
      cogRel = 0;
    end
    e = {!pllRel, !hubRel, !cogRel, boot, !cogRel, mCause};
  endtask

  task checkOutput(input logic [7:0] act, input logic [7:0] exp, input int cyc);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL outputs cyc=%0d actual=%b required=%b (pll,hub,cog,boot,busy,cause)",
               cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the response
  // expected after the next rising edge.
  task applyStimulus(input bit r, input bit f, input bit sw, input bit lk,
                     input bit kk, input bit cl);
    logic [7:0] e;
    @(negedge clk);
    res       = r;
    ext_fault = f;
    sw_reboot = sw;
    pll_lock  = lk;
    wdt_kick  = kk;
    cause_clr = cl;
    modelStep(r, f, sw, lk, kk, cl, e);
    expQ.push_back(e);
  endtask

  task runCycles(input int n, input bit lk, input int kickEvery, input bit f);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, f, 1'b0, lk,
                    (kickEvery > 0) && (i % kickEvery == kickEvery - 1), 1'b0);
    end
  endtask

  // Monitor: compares DUT outputs shortly after each rising edge.
  initial begin
    logic [7:0] e;
    int mcyc;
    mcyc = 0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({res_pll, res_hub, res_cog, boot_start, busy, cause}, e, mcyc);
      end
    end
  end

  initial begin
    $display("[TB] start");

    // Power-on sequence with lock present
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    runCycles(80, 1'b1, 20, 1'b0);

    // Lock withheld: hub must stall until lock arrives
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles(230, 1'b0, 20, 1'b0);
    runCycles(40, 1'b1, 20, 1'b0);

    // Software reboot from RUN
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(60, 1'b1, 20, 1'b0);

    // Fault burst while waiting on the PLL
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(22, 1'b1, 0, 1'b0);
    runCycles(5, 1'b1, 0, 1'b1);
    runCycles(60, 1'b1, 20, 1'b0);

    // Watchdog: no kicks, then steady kicks
    runCycles(300, 1'b1, 0, 1'b0);
    runCycles(1000, 1'b1, 50, 1'b0);

    // Clear and reboot together, then clear alone
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    runCycles(60, 1'b1, 20, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles(10, 1'b1, 20, 1'b0);

    // Random mix of every source
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 79) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 39) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
